// File: rtl/bound_flasher_gen.sv
// Bound flasher: a registered thermometer LED bar that sweeps up and down through a
// programmable table of phase targets; flick starts a sequence and can kick it back.
module bound_flasher_gen #(
  parameter int unsigned N       = 16,
  parameter int unsigned PHASES  = 6,
  parameter int unsigned DIV     = 1,
  parameter int unsigned KICK_LO = 0,
  parameter int unsigned KICK_HI = 6,
  localparam int unsigned CW = $clog2(N + 1),
  localparam int unsigned PW = $clog2(PHASES),
  parameter logic [PHASES*CW-1:0] TBL_INIT = {CW'(0), CW'(6), CW'(0), CW'(11), CW'(6), CW'(16)}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flick,
  input  logic          cfg_we,
  input  logic [PW-1:0] cfg_addr,
  input  logic [CW-1:0] cfg_data,
  output logic [N-1:0]  LED,
  output logic          busy,
  output logic          done
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LastP = PW'(PHASES - 1);
  localparam logic [CW-1:0] Full  = CW'(N);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] p_q, p_d;
  logic [CW-1:0] c_q, c_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  led_q, led_d;
  logic          done_q, done_d;

  logic          flick_s1_q, flick_s2_q, flick_s3_q;
  logic          flick_evt;
  logic [CW-1:0] tbl_q [PHASES];
  logic [CW-1:0] wr_val;
  logic [CW-1:0] tgt;
  logic          up, tick, complete, kick;

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flick_s1_q <= 1'b0;
      flick_s2_q <= 1'b0;
      flick_s3_q <= 1'b0;
    end else begin
      flick_s1_q <= flick;
      flick_s2_q <= flick_s1_q;
      flick_s3_q <= flick_s2_q;
    end
  end

  assign flick_evt = flick_s2_q & ~flick_s3_q;

  assign wr_val = (cfg_data > Full) ? Full : cfg_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < PHASES; i++) begin
        tbl_q[i] <= TBL_INIT[i*CW +: CW];
      end
    end else if (cfg_we && (state_q == StIdle) && (32'(cfg_addr) < PHASES)) begin
      tbl_q[cfg_addr] <= wr_val;
    end
  end

  function automatic logic [CW-1:0] step(input logic [CW-1:0] val, input logic dir_up);
    if (dir_up) begin
      return (val == Full) ? val : val + CW'(1);
    end
    return (val == '0) ? val : val - CW'(1);
  endfunction

  assign tgt      = tbl_q[p_q];
  assign up       = ~p_q[0];
  assign tick     = (state_q == StRun) && (cnt_q == DW'(DIV - 1));
  assign complete = up ? (c_q >= tgt) : (c_q <= tgt);
  assign kick     = (state_q == StRun) && flick_evt && p_q[0] && (p_q != LastP) &&
                    ((c_q == CW'(KICK_LO)) || (c_q == CW'(KICK_HI)));

  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flick_evt) begin
          state_d = StRun;
          p_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // A kick wins over a coincident tick: back one phase, count held.
        if (kick) begin
          p_d   = p_q - PW'(1);
          cnt_d = '0;
        end else if (tick) begin
          cnt_d = '0;
          if (!complete) begin
            c_d = step(c_q, up);
          end else if (p_q == LastP) begin
            state_d = StIdle;
            c_d     = '0;
            done_d  = 1'b1;
          end else begin
            p_d = p_q + PW'(1);
            c_d = step(c_q, ~up);
          end
        end else begin
          cnt_d = cnt_q + DW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    led_d = '0;
    for (int unsigned i = 0; i < N; i++) begin
      led_d[i] = (CW'(i) < c_d);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      p_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      led_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign LED  = led_q;
  assign busy = (state_q == StRun);
  assign done = done_q;

endmodule
